// File: rtl/downsampler_pkg.sv
// Shared types and constants for the multichannel downsampler.
package downsampler_pkg;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_SUM  = 1'b1
  } mode_e;

  localparam int RATE_DEFAULT = 1;

  // Accumulator width that cannot overflow when summing up to 2^rate_width-1 samples.
  function automatic int acc_width(input int data_width, input int rate_width);
    return data_width + rate_width;
  endfunction

endpackage

// File: rtl/downsampler_multichannel_if.sv
// AXI-stream style data channel (tdata/tvalid/tready/tlast) with master/slave views.
interface downsampler_multichannel_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-stage output register: holds tdata/tlast while the consumer stalls.
module axis_out_reg #(
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     load_last,
  output logic                     can_accept,
  downsampler_multichannel_if.master m
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m.tvalid <= 1'b0;
      m.tdata  <= '0;
      m.tlast  <= 1'b0;
    end else if (load) begin
      m.tvalid <= 1'b1;
      m.tdata  <= load_data;
      m.tlast  <= load_last;
    end else if (m.tready) begin
      m.tvalid <= 1'b0;
    end
  end

  // A new load is only safe when the held word is empty or leaving this cycle.
  assign can_accept = reset_n && (!m.tvalid || m.tready);

endmodule

// File: rtl/downsampler_multichannel.sv
// Decimates an interleaved multichannel stream by R frames, picking or summing per channel.
module downsampler_multichannel
  import downsampler_pkg::*;
#(
  parameter int DATA_WIDTH_INP  = 8,
  parameter int DATA_WIDTH_RATE = 16,
  parameter int NUM_CH          = 4,
  parameter int ACC_WIDTH       = acc_width(DATA_WIDTH_INP, DATA_WIDTH_RATE)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  downsampler_multichannel_if.slave  s_axis_in,
  input  logic [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata,
  input  logic                       s_axis_rate_tvalid,
  input  logic                       cfg_mode,
  downsampler_multichannel_if.master m_axis_out,
  output logic                       frame_err
);

  localparam int                         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]            CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [DATA_WIDTH_RATE-1:0] RATE_RST = DATA_WIDTH_RATE'(RATE_DEFAULT);

  logic [CH_W-1:0]            ch;
  logic [DATA_WIDTH_RATE-1:0] fc;
  logic [DATA_WIDTH_RATE-1:0] rate_act, rate_pend, rate_in, rate_new;
  mode_e                      mode_act, mode_pend, mode_new;
  logic                       pend_valid;
  logic signed [ACC_WIDTH-1:0] acc [NUM_CH];

  logic signed [DATA_WIDTH_INP-1:0] sample;
  logic signed [ACC_WIDTH-1:0]      sample_ext, acc_sum, out_data;
  logic xfer, last_ch, mismatch, good, decim, load, boundary, apply, can_accept;

  assign s_axis_in.tready = can_accept;
  assign sample           = s_axis_in.tdata;
  assign sample_ext       = ACC_WIDTH'(sample);
  assign xfer             = s_axis_in.tvalid && can_accept;
  assign last_ch          = (ch == CH_LAST);
  assign mismatch         = xfer && (s_axis_in.tlast != last_ch);
  assign good             = xfer && !mismatch;
  assign decim            = (fc == rate_act - 1'b1);
  assign load             = good && decim;

  assign acc_sum  = acc[ch] + sample_ext;
  assign out_data = (mode_act == MODE_SUM) ? acc_sum : sample_ext;

  // Frame boundary: idle at the start of a frame, or completing its last channel.
  assign boundary = xfer ? (good && last_ch) : (ch == '0);
  assign apply    = boundary && (pend_valid || s_axis_rate_tvalid);
  assign rate_in  = (s_axis_rate_tdata == '0) ? RATE_RST : s_axis_rate_tdata;
  assign rate_new = s_axis_rate_tvalid ? rate_in : rate_pend;
  assign mode_new = s_axis_rate_tvalid ? mode_e'(cfg_mode) : mode_pend;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch         <= '0;
      fc         <= '0;
      rate_act   <= RATE_RST;
      rate_pend  <= RATE_RST;
      mode_act   <= MODE_PICK;
      mode_pend  <= MODE_PICK;
      pend_valid <= 1'b0;
      frame_err  <= 1'b0;
      // NOTE: the accumulators are a flop array, not RAM, so they are reset to drop partial sums.
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      if (mismatch) begin
        frame_err <= 1'b1;
        ch        <= '0;
        fc        <= '0;
        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else if (good) begin
        acc[ch] <= decim ? '0 : acc_sum;
        ch      <= last_ch ? '0 : ch + 1'b1;
        if (last_ch) fc <= decim ? '0 : fc + 1'b1;
      end

      // New settings take effect after the boundary transfer used the old ones.
      if (apply) begin
        rate_act   <= rate_new;
        mode_act   <= mode_new;
        pend_valid <= 1'b0;
        fc         <= '0;
        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else if (s_axis_rate_tvalid) begin
        rate_pend  <= rate_in;
        mode_pend  <= mode_e'(cfg_mode);
        pend_valid <= 1'b1;
      end
    end
  end

  axis_out_reg #(.WIDTH(ACC_WIDTH)) u_out_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_data  (out_data),
    .load_last  (last_ch),
    .can_accept (can_accept),
    .m          (m_axis_out)
  );

endmodule
